tmr_scrub_controller: RTL and testbench

//  Sequences a shared triplicated register array: periodic scrubbing plus host reads/writes.

---
 rtl/tmr_scrub_if.sv | 21 ++
 rtl/tmr_scrub_controller.sv | 218 +++++++++++++++++++++
 tb/tb_tmr_scrub_controller.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tmr_scrub_if.sv
// Host bus for the TMR scrub controller.
//
// Handshake: the master raises req with we/addr/wdata stable and holds them
// until it samples gnt high on a rising edge. gnt is a one-cycle pulse; the
// request is consumed on that edge. For reads, rvalid pulses for one cycle
// exactly two cycles after gnt, with rdata valid only while rvalid is high.
interface tmr_scrub_if #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic              gnt;
    logic              rvalid;
    logic [WIDTH-1:0]  rdata;

    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/tmr_scrub_controller.sv
// TMR scrub controller: arbitrates host reads/writes and periodic scrubbing of
// a triplicated word array. Scrub reads copies A/B/C, votes, and repairs a
// single deviating copy while counting errors per domain.
// Optional feature macro: TMR_SCRUB_IRQ_EN (adds o_irq / i_irq_clr).
module tmr_scrub_controller #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 16,
    parameter int SCRUB_PERIOD = 256,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_scrub_en,
    tmr_scrub_if.slave               host,
    output logic [$clog2(DEPTH)-1:0] o_mem_addr,
    input  logic [WIDTH-1:0]         i_mem_rdA,
    input  logic [WIDTH-1:0]         i_mem_rdB,
    input  logic [WIDTH-1:0]         i_mem_rdC,
    output logic                     o_mem_weA,
    output logic                     o_mem_weB,
    output logic                     o_mem_weC,
    output logic [WIDTH-1:0]         o_mem_wdata,
    output logic [ERR_CNT_W-1:0]     o_errA_cnt,
    output logic [ERR_CNT_W-1:0]     o_errB_cnt,
    output logic [ERR_CNT_W-1:0]     o_errC_cnt,
    output logic                     o_err_multi,
    input  logic                     i_cnt_clr,
    output logic                     o_busy,
    output logic [2:0]               o_dbg_state
`ifdef TMR_SCRUB_IRQ_EN
    ,
    output logic                     o_irq,
    input  logic                     i_irq_clr
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HRD   = 3'd1,
        S_HVOTE = 3'd2,
        S_HWR   = 3'd3,
        S_SRD   = 3'd4,
        S_SVOTE = 3'd5,
        S_SFIX  = 3'd6
    } state_t;

    state_t               r_state;
    logic [TW-1:0]        r_timer;
    logic                 r_scrub_pend;
    logic [AW-1:0]        r_scrub_ptr;
    logic                 r_last_host;
    logic [AW-1:0]        r_mem_addr;
    logic [WIDTH-1:0]     r_wdata;
    logic [2:0]           r_fix_sel;
    logic                 r_err_multi;
    logic [ERR_CNT_W-1:0] r_errA;
    logic [ERR_CNT_W-1:0] r_errB;
    logic [ERR_CNT_W-1:0] r_errC;

    logic             w_tick;
    logic [WIDTH-1:0] w_maj;
    logic             w_devA;
    logic             w_devB;
    logic             w_devC;
    logic             w_single;
    logic             w_multi;
    logic             w_gnt_host;
    logic             w_incA;
    logic             w_incB;
    logic             w_incC;

    assign w_tick = (r_timer == TW'(SCRUB_PERIOD - 1));

    // Bitwise majority; a copy deviates if it differs from the vote anywhere.
    // Exactly one deviating copy means the other two agree and it can be
    // repaired; two or more deviating copies means no pair agrees.
    assign w_maj    = (i_mem_rdA & i_mem_rdB) | (i_mem_rdA & i_mem_rdC) | (i_mem_rdB & i_mem_rdC);
    assign w_devA   = |(i_mem_rdA ^ w_maj);
    assign w_devB   = |(i_mem_rdB ^ w_maj);
    assign w_devC   = |(i_mem_rdC ^ w_maj);
    assign w_single = (w_devA ^ w_devB ^ w_devC) & ~(w_devA & w_devB & w_devC);
    assign w_multi  = (w_devA & w_devB) | (w_devA & w_devC) | (w_devB & w_devC);

    // Host wins when no scrub is pending or when the scrub side went last.
    assign w_gnt_host = !i_rst && (r_state == S_IDLE) && host.req &&
                        (!r_scrub_pend || !r_last_host);

    assign w_incA = (r_state == S_SFIX) && r_fix_sel[0];
    assign w_incB = (r_state == S_SFIX) && r_fix_sel[1];
    assign w_incC = (r_state == S_SFIX) && r_fix_sel[2];

    // Write enables are decoded from state and gated by reset so that a reset
    // landing in HWR/SFIX never lets a write through.
    assign o_mem_weA   = !i_rst && ((r_state == S_HWR) || w_incA);
    assign o_mem_weB   = !i_rst && ((r_state == S_HWR) || w_incB);
    assign o_mem_weC   = !i_rst && ((r_state == S_HWR) || w_incC);
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_wdata;

    assign host.gnt    = w_gnt_host;
    assign host.rvalid = !i_rst && (r_state == S_HVOTE);
    assign host.rdata  = (!i_rst && (r_state == S_HVOTE)) ? w_maj : '0;

    assign o_errA_cnt  = r_errA;
    assign o_errB_cnt  = r_errB;
    assign o_errC_cnt  = r_errC;
    assign o_err_multi = r_err_multi;
    assign o_busy      = (r_state != S_IDLE);
    assign o_dbg_state = r_state;

    // Scrub timer and pending flag; a tick while pending merges, a tick in
    // the same cycle as the SRD clear keeps the request alive.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_timer      <= '0;
            r_scrub_pend <= 1'b0;
        end else begin
            if (i_scrub_en) begin
                r_timer <= w_tick ? '0 : r_timer + 1'b1;
            end
            if (i_scrub_en && w_tick) begin
                r_scrub_pend <= 1'b1;
            end else if (r_state == S_SRD) begin
                r_scrub_pend <= 1'b0;
            end
        end
    end

    // Main sequencer: arbitration, address/data registers, scrub pointer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_scrub_ptr <= '0;
            r_last_host <= 1'b0;
            r_mem_addr  <= '0;
            r_wdata     <= '0;
            r_fix_sel   <= '0;
            r_err_multi <= 1'b0;
        end else begin
            r_err_multi <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_host) begin
                        r_last_host <= 1'b1;
                        r_mem_addr  <= host.addr;
                        if (host.we) begin
                            r_wdata <= host.wdata;
                            r_state <= S_HWR;
                        end else begin
                            r_state <= S_HRD;
                        end
                    end else if (r_scrub_pend) begin
                        r_last_host <= 1'b0;
                        r_mem_addr  <= r_scrub_ptr;
                        r_state     <= S_SRD;
                    end
                end
                S_HRD:   r_state <= S_HVOTE;
                S_HVOTE: r_state <= S_IDLE;
                S_HWR:   r_state <= S_IDLE;
                S_SRD:   r_state <= S_SVOTE;
                S_SVOTE: begin
                    r_scrub_ptr <= (r_scrub_ptr == AW'(DEPTH - 1)) ? '0 : r_scrub_ptr + 1'b1;
                    if (w_single) begin
                        r_wdata   <= w_maj;
                        r_fix_sel <= {w_devC, w_devB, w_devA};
                        r_state   <= S_SFIX;
                    end else begin
                        r_err_multi <= w_multi;
                        r_state     <= S_IDLE;
                    end
                end
                S_SFIX:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Saturating per-domain error counters; clear beats increment.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_cnt_clr) begin
            r_errA <= '0;
            r_errB <= '0;
            r_errC <= '0;
        end else begin
            if (w_incA && (r_errA != CNT_MAX)) r_errA <= r_errA + 1'b1;
            if (w_incB && (r_errB != CNT_MAX)) r_errB <= r_errB + 1'b1;
            if (w_incC && (r_errC != CNT_MAX)) r_errC <= r_errC + 1'b1;
        end
    end

`ifdef TMR_SCRUB_IRQ_EN
    logic r_irq;
    logic w_irq_set;

    assign w_irq_set = ((r_state == S_SVOTE) && w_multi) ||
                       (!i_cnt_clr && w_incA && (r_errA == CNT_MAX - 1'b1)) ||
                       (!i_cnt_clr && w_incB && (r_errB == CNT_MAX - 1'b1)) ||
                       (!i_cnt_clr && w_incC && (r_errC == CNT_MAX - 1'b1));
    assign o_irq = r_irq;

    // Sticky interrupt; a new event outranks a simultaneous clear.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_irq <= 1'b0;
        end else if (w_irq_set) begin
            r_irq <= 1'b1;
        end else if (i_irq_clr) begin
            r_irq <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_tmr_scrub_controller.sv
// Directed testbench for tmr_scrub_controller with a behavioural
// triplicated memory (one-cycle read latency, optional stuck bit on copy B).
module tb_tmr_scrub_controller;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;
    localparam int P  = 8;
    localparam int CW = 8;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SRD  = 3'd4;
    localparam logic [2:0] ST_SFIX = 3'd6;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          scrub_en = 1'b0;
    logic          cnt_clr  = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  rd_a = '0;
    logic [W-1:0]  rd_b = '0;
    logic [W-1:0]  rd_c = '0;
    logic          we_a, we_b, we_c;
    logic [W-1:0]  wdata;
    logic [CW-1:0] err_a, err_b, err_c;
    logic          err_multi;
    logic          busy;
    logic [2:0]    dbg_state;

    tmr_scrub_if #(.WIDTH(W), .ADDR_W(AW)) host ();

    tmr_scrub_controller #(
        .WIDTH(W), .DEPTH(D), .SCRUB_PERIOD(P), .ERR_CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_scrub_en(scrub_en), .host(host),
        .o_mem_addr(mem_addr),
        .i_mem_rdA(rd_a), .i_mem_rdB(rd_b), .i_mem_rdC(rd_c),
        .o_mem_weA(we_a), .o_mem_weB(we_b), .o_mem_weC(we_c),
        .o_mem_wdata(wdata),
        .o_errA_cnt(err_a), .o_errB_cnt(err_b), .o_errC_cnt(err_c),
        .o_err_multi(err_multi), .i_cnt_clr(cnt_clr), .o_busy(busy),
        .o_dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural memory with backdoor load port
    logic [W-1:0]  mem_a [D];
    logic [W-1:0]  mem_b [D];
    logic [W-1:0]  mem_c [D];
    logic          bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [W-1:0]  bd_a = '0, bd_b = '0, bd_c = '0;
    logic          stuck_b = 1'b0;

    always @(posedge clk) begin
        rd_a <= mem_a[mem_addr];
        rd_b <= mem_b[mem_addr] ^ (stuck_b ? 8'h01 : 8'h00);
        rd_c <= mem_c[mem_addr];
        if (bd_en) begin
            mem_a[bd_addr] <= bd_a;
            mem_b[bd_addr] <= bd_b;
            mem_c[bd_addr] <= bd_c;
        end else begin
            if (we_a) mem_a[mem_addr] <= wdata;
            if (we_b) mem_b[mem_addr] <= wdata;
            if (we_c) mem_c[mem_addr] <= wdata;
        end
    end

    // Monitor: event counters and logs, sampled on the falling edge
    int            we_cnt    = 0;
    int            fix_cnt   = 0;
    int            multi_cnt = 0;
    logic [2:0]    fix_mask  = '0;
    logic [AW-1:0] fix_addr  = '0;
    logic [W-1:0]  fix_data  = '0;
    logic [AW-1:0] srd_q[$];
    logic          svc_q[$];

    always @(negedge clk) begin
        if (we_a | we_b | we_c) we_cnt <= we_cnt + 1;
        if (err_multi) multi_cnt <= multi_cnt + 1;
        if (!rst && dbg_state == ST_SFIX) begin
            fix_cnt  <= fix_cnt + 1;
            fix_mask <= {we_c, we_b, we_a};
            fix_addr <= mem_addr;
            fix_data <= wdata;
        end
        if (!rst && dbg_state == ST_SRD) begin
            srd_q.push_back(mem_addr);
            svc_q.push_back(1'b0);
        end
        if (host.gnt) svc_q.push_back(1'b1);
    end

    // Scoreboard counters
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int addr, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c);
        bd_addr = AW'(addr);
        bd_a = a;
        bd_b = b;
        bd_c = c;
        bd_en = 1'b1;
        @(posedge clk);
        #1;
        bd_en = 1'b0;
    endtask

    // Raise a request and return one cycle after the grant cycle.
    task automatic host_issue(input logic we, input logic [AW-1:0] addr,
                              input logic [W-1:0] data, output bit got);
        got = 1'b0;
        host.req = 1'b1;
        host.we = we;
        host.addr = addr;
        host.wdata = data;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            if (host.gnt) got = 1'b1;
        end
        @(posedge clk);
        #1;
        host.req = 1'b0;
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        int n;
        int base_we, base_fix, base_multi, base_srd, sz;
        int hc, sc, ss;
        bit got;

        host.req = 1'b0;
        host.we = 1'b0;
        host.addr = '0;
        host.wdata = '0;
        for (int i = 0; i < D; i++) poke(i, 8'h00, 8'h00, 8'h00);

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_gnt", host.gnt, 0);
        chk("rst_rvalid", host.rvalid, 0);
        chk("rst_rdata", host.rdata, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_we", {we_a, we_b, we_c}, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_cnt", {err_a, err_b, err_c}, 0);
        chk("rst_multi", err_multi, 0);

        // 1: clean array, scrub pointer walks 0..15 then wraps
        @(posedge clk); #1;
        rst = 1'b0;
        scrub_en = 1'b1;
        base_we = we_cnt;
        base_multi = multi_cnt;
        base_srd = srd_q.size();
        n = 0;
        while (srd_q.size() < base_srd + 17 && n < 1000) begin @(posedge clk); n++; end
        #1;
        chk("t1_wait", srd_q.size() >= base_srd + 17, 1);
        for (int i = 0; i < 17 && base_srd + i < srd_q.size(); i++)
            chk("t1_ptr", srd_q[base_srd + i], i % 16);
        chk("t1_we", we_cnt - base_we, 0);
        chk("t1_cnt", {err_a, err_b, err_c}, 0);
        chk("t1_multi", multi_cnt - base_multi, 0);

        // 2: single-copy error in C on word 3 is repaired
        poke(3, 8'h5A, 8'h5A, 8'h7A);
        base_fix = fix_cnt;
        n = 0;
        while (fix_cnt == base_fix && n < 1000) begin @(posedge clk); n++; end
        @(negedge clk);
        chk("t2_wait", fix_cnt > base_fix, 1);
        chk("t2_mask", fix_mask, 3'b100);
        chk("t2_addr", fix_addr, 3);
        chk("t2_data", fix_data, 8'h5A);
        chk("t2_cnt", {err_a, err_b, err_c}, 24'h000001);
        @(negedge clk);
        chk("t2_mem_c", mem_c[3], 8'h5A);

        // 3: all copies differ on word 5 -> err_multi, no write, ptr advances
        poke(5, 8'h01, 8'h02, 8'h04);
        base_we = we_cnt;
        base_multi = multi_cnt;
        n = 0;
        while (multi_cnt == base_multi && n < 1000) begin @(posedge clk); n++; end
        #1;
        chk("t3_wait", multi_cnt > base_multi, 1);
        chk("t3_last_srd", srd_q[$], 5);
        chk("t3_we", we_cnt - base_we, 0);
        chk("t3_cnt", {err_a, err_b, err_c}, 24'h000001);
        sz = srd_q.size();
        n = 0;
        while (srd_q.size() == sz && n < 100) begin @(posedge clk); n++; end
        #1;
        chk("t3_next_srd", srd_q[$], 6);
        scrub_en = 1'b0;

        // 4: host write then reads; read latency and majority vote
        host_issue(1'b1, 4'd7, 8'hC3, got);
        chk("t4_wr_gnt", got, 1);
        @(negedge clk);
        chk("t4_wr_we", {we_a, we_b, we_c}, 3'b111);
        chk("t4_wr_addr", mem_addr, 7);
        chk("t4_wr_data", wdata, 8'hC3);
        host_issue(1'b0, 4'd7, 8'h00, got);
        chk("t4_rd_gnt", got, 1);
        @(negedge clk);
        chk("t4_rv_t1", host.rvalid, 0);
        @(negedge clk);
        chk("t4_rv_t2", host.rvalid, 1);
        chk("t4_rdata", host.rdata, 8'hC3);
        poke(9, 8'hF0, 8'hCC, 8'hAA);
        base_we = we_cnt;
        host_issue(1'b0, 4'd9, 8'h00, got);
        @(negedge clk);
        @(negedge clk);
        chk("t4_vote_rv", host.rvalid, 1);
        chk("t4_vote", host.rdata, 8'hE8);
        chk("t4_rd_we", we_cnt - base_we, 0);
        chk("t4_rd_cnt", {err_a, err_b, err_c}, 24'h000001);

        // 5: host request held while scrubs keep arriving
        @(posedge clk); #1;
        base_srd = svc_q.size();
        host.req = 1'b1;
        host.we = 1'b0;
        host.addr = 4'd0;
        scrub_en = 1'b1;
        repeat (96) @(posedge clk);
        #1;
        host.req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        hc = 0; sc = 0; ss = 0;
        for (int i = base_srd; i < svc_q.size(); i++) begin
            if (svc_q[i]) hc++; else sc++;
            if (i > base_srd && !svc_q[i] && !svc_q[i-1]) ss++;
        end
        chk("t5_host_served", hc >= 8, 1);
        chk("t5_scrub_served", sc >= 8, 1);
        chk("t5_no_scrub_twice", ss, 0);

        // 6: clear, clear-beats-increment, saturation, reset inside SFIX
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("t6_clr", {err_a, err_b, err_c}, 0);
        stuck_b = 1'b1;
        n = 0;
        while (dbg_state != ST_SFIX && n < 200) begin @(posedge clk); #1; n++; end
        chk("t6_sfix1", dbg_state, ST_SFIX);
        cnt_clr = 1'b1;
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk("t6_clr_wins", err_b, 0);
        n = 0;
        while (err_b != 8'hFF && n < 6000) begin @(posedge clk); #1; n++; end
        chk("t6_sat_reach", err_b, 8'hFF);
        base_fix = fix_cnt;
        n = 0;
        while (fix_cnt == base_fix && n < 500) begin @(posedge clk); n++; end
        @(negedge clk);
        chk("t6_fix_b", fix_mask, 3'b010);
        chk("t6_sat_hold", err_b, 8'hFF);
        @(posedge clk); #1;
        n = 0;
        while (dbg_state != ST_SFIX && n < 200) begin @(posedge clk); #1; n++; end
        chk("t6_sfix2", dbg_state, ST_SFIX);
        base_we = we_cnt;
        rst = 1'b1;
        #1;
        chk("t6_rst_we", {we_a, we_b, we_c}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        scrub_en = 1'b0;
        @(negedge clk);
        chk("t6_rst_we_cnt", we_cnt - base_we, 0);
        chk("t6_post_state", dbg_state, ST_IDLE);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_cnt", {err_a, err_b, err_c}, 0);
        chk("t6_post_addr", mem_addr, 0);
        chk("t6_post_wdata", wdata, 0);
        chk("t6_post_multi", err_multi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
